// File: rtl/sfifo_unpacker_pkg.sv
// -----------------------------------------------------------------------------
// sfifo_unpacker_pkg
// Helpers shared by the FIFO packer/unpacker pair:
//   lane_idx_w() - width of a lane index for a given lane count
//   lane_lsb()   - lane slice convention: lane k occupies bits [k*bw +: bw]
// Optional feature macro used by the unpacker: SFIFO_UNPACKER_CHECK_EN
// -----------------------------------------------------------------------------
package sfifo_unpacker_pkg;

    // At least one bit so a lane index is always a legal vector.
    function automatic int lane_idx_w(input int nlane);
        return (nlane > 1) ? $clog2(nlane) : 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int bw);
        return lane * bw;
    endfunction

endpackage : sfifo_unpacker_pkg

// File: rtl/sfifo_unpack_prienc.sv
// -----------------------------------------------------------------------------
// sfifo_unpack_prienc
// Combinational lowest-set-bit encoder.
// Ports:
//   i_vec    [NLANE] input vector
//   o_idx    [LW]    index of the lowest set bit (0 when i_vec == 0)
//   o_onehot [NLANE] one-hot of the lowest set bit (0 when i_vec == 0)
//   o_single         exactly one bit of i_vec is set
// -----------------------------------------------------------------------------
module sfifo_unpack_prienc
    import sfifo_unpacker_pkg::*;
#(
    parameter  int NLANE = 4,
    localparam int LW    = lane_idx_w(NLANE)
) (
    input  logic [NLANE-1:0] i_vec,
    output logic [LW-1:0]    o_idx,
    output logic [NLANE-1:0] o_onehot,
    output logic             o_single
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        o_idx    = '0;
        o_onehot = '0;
        // Scan from the top so the lowest set bit is the last one written.
        for (int k = NLANE - 1; k >= 0; k--) begin
            if (i_vec[k]) begin
                o_idx       = LW'(k);
                o_onehot    = '0;
                o_onehot[k] = 1'b1;
            end
        end
    end

    // Clearing the selected bit leaves nothing behind, and something was set.
    assign o_single = (|i_vec) && ((i_vec & ~o_onehot) == '0);

endmodule : sfifo_unpack_prienc

// File: rtl/sfifo_unpacker.sv
// -----------------------------------------------------------------------------
// sfifo_unpacker
// Pops one packed word (NLANE lanes of BW bits plus a lane-valid mask) from a
// FIFO read port and replays the valid lanes one item per handshake, lowest
// lane first. A new word is taken in the same cycle the last item of the
// current word is consumed, so consecutive words stream without a bubble.
// Ports:
//   i_clk, i_rst          clock (rising edge), async reset (active low)
//   src_rdy / src_ack     packed word available / consumed this cycle
//   i_data [NLANE*BW]     packed word, lane k = i_data[k*BW +: BW]
//   i_mask [NLANE]        lane valid mask
//   dst_rdy / dst_ack     item available / item consumed
//   o_data [BW]           current item
//   o_lane [LW]           lane index of the current item
//   o_last                current item is the final valid lane of its word
// Optional: define SFIFO_UNPACKER_CHECK_EN for simulation-only protocol checks.
// -----------------------------------------------------------------------------
module sfifo_unpacker
    import sfifo_unpacker_pkg::*;
#(
    parameter  int NLANE = 4,
    parameter  int BW    = 8,
    localparam int LW    = lane_idx_w(NLANE)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                src_rdy,
    output logic                src_ack,
    input  logic [NLANE*BW-1:0] i_data,
    input  logic [NLANE-1:0]    i_mask,
    output logic                dst_rdy,
    input  logic                dst_ack,
    output logic [BW-1:0]       o_data,
    output logic [LW-1:0]       o_lane,
    output logic                o_last
);

    logic [NLANE*BW-1:0] word_q, word_d;
    logic [NLANE-1:0]    rem_q, rem_d;     // lanes of word_q not yet emitted

    logic [LW-1:0]       sel_idx;
    logic [NLANE-1:0]    sel_onehot;
    logic                sel_single;

    sfifo_unpack_prienc #(
        .NLANE (NLANE)
    ) u_prienc (
        .i_vec    (rem_q),
        .o_idx    (sel_idx),
        .o_onehot (sel_onehot),
        .o_single (sel_single)
    );

    // Outputs come from registered state only; no i_data -> o_data path.
    assign dst_rdy = |rem_q;
    assign o_lane  = sel_idx;
    assign o_last  = sel_single;
    assign o_data  = word_q[lane_lsb(int'(sel_idx), BW) +: BW];

    // Take a new word when idle, or when the final item leaves this cycle.
    assign src_ack = src_rdy && (!dst_rdy || (dst_ack && o_last));

    always_comb begin
        word_d = word_q;
        rem_d  = rem_q;
        if (src_ack) begin
            // A new word overrides the clear of the item leaving this cycle.
            word_d = i_data;
            rem_d  = i_mask;
        end else if (dst_ack && dst_rdy) begin
            rem_d = rem_q & ~sel_onehot;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the next-state
    // values are computed with blocking assignments in the always_comb above.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            // NOTE: the data register is reset too so o_data reads 0 out of reset.
            word_q <= '0;
            rem_q  <= '0;
        end else begin
            word_q <= word_d;
            rem_q  <= rem_d;
        end
    end

`ifdef SFIFO_UNPACKER_CHECK_EN
    always @(posedge i_clk) begin
        if (i_rst) begin
            if (dst_ack && !dst_rdy)
                $error("sfifo_unpacker: dst_ack while dst_rdy=0");
            if (src_ack && !src_rdy)
                $error("sfifo_unpacker: src_ack while src_rdy=0");
            if (!src_ack && !(dst_ack && dst_rdy) && (rem_d != rem_q))
                $error("sfifo_unpacker: lane mask changed without a handshake");
        end
    end
`endif

endmodule : sfifo_unpacker

// File: tb/tb_sfifo_unpacker.sv
// -----------------------------------------------------------------------------
// tb_sfifo_unpacker
// Scoreboard bench: every accepted word expands into its expected item list,
// a monitor pops and compares on each item handshake.
// -----------------------------------------------------------------------------
module tb_sfifo_unpacker;

    localparam int NLANE = 4;
    localparam int BW    = 8;
    localparam int LW    = 2;

    typedef struct {
        logic [BW-1:0] data;
        logic [LW-1:0] lane;
        logic          last;
    } item_t;

    logic                i_clk;
    logic                i_rst;
    logic                src_rdy;
    logic                src_ack;
    logic [NLANE*BW-1:0] i_data;
    logic [NLANE-1:0]    i_mask;
    logic                dst_rdy;
    logic                dst_ack;
    logic [BW-1:0]       o_data;
    logic [LW-1:0]       o_lane;
    logic                o_last;

    int    n_checks = 0;
    int    n_errors = 0;
    int    ack_pct  = 100;
    item_t exp_q[$];

    sfifo_unpacker #(.NLANE(NLANE), .BW(BW)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .src_rdy (src_rdy),
        .src_ack (src_ack),
        .i_data  (i_data),
        .i_mask  (i_mask),
        .dst_rdy (dst_rdy),
        .dst_ack (dst_ack),
        .o_data  (o_data),
        .o_lane  (o_lane),
        .o_last  (o_last)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference expansion of one packed word into its item sequence.
    task automatic push_word(input logic [NLANE*BW-1:0] d, input logic [NLANE-1:0] m);
        int top;
        item_t it;
        top = -1;
        for (int k = 0; k < NLANE; k++) if (m[k]) top = k;
        for (int k = 0; k < NLANE; k++) begin
            if (m[k]) begin
                it.data = d[k*BW +: BW];
                it.lane = LW'(k);
                it.last = (k == top);
                exp_q.push_back(it);
            end
        end
    endtask

    // Consumer: acknowledges only while an item is offered.
    always @(posedge i_clk) begin
        #1;
        if (i_rst)
            dst_ack = dst_rdy && ($urandom_range(0, 99) < ack_pct);
    end

    // Monitor: model-level expectations of handshakes, then scoreboard pop/push.
    always @(negedge i_clk) begin
        if (i_rst) begin
            item_t it;
            check("dst_rdy", 32'(dst_rdy), 32'(exp_q.size() != 0));
            // The queue only ever holds the current word's remaining items.
            check("src_ack", 32'(src_ack),
                  32'(src_rdy && (exp_q.size() == 0 || (dst_ack && exp_q.size() == 1))));
            if (dst_rdy && dst_ack) begin
                if (exp_q.size() == 0) begin
                    check("item_underflow", 32'(1), 32'(0));
                end else begin
                    it = exp_q.pop_front();
                    check("o_data", 32'(o_data), 32'(it.data));
                    check("o_lane", 32'(o_lane), 32'(it.lane));
                    check("o_last", 32'(o_last), 32'(it.last));
                end
            end
            if (src_ack) push_word(i_data, i_mask);
        end
    end

    // Offer one word and hold it until taken; returns 1 ns after the accepting edge.
    task automatic drive(input logic [NLANE*BW-1:0] d, input logic [NLANE-1:0] m);
        bit acc;
        bit done;
        done    = 1'b0;
        src_rdy = 1'b1;
        i_data  = d;
        i_mask  = m;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge i_clk);
            acc = src_ack;
            @(posedge i_clk);
            #1;
            if (acc) done = 1'b1;
        end
        src_rdy = 1'b0;
        if (!done) check("src_ack_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dst_rdy) && n < 1000) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        logic [BW-1:0] hold_data;
        logic [LW-1:0] hold_lane;

        i_rst   = 1'b0;
        src_rdy = 1'b0;
        dst_ack = 1'b0;
        i_data  = '0;
        i_mask  = '0;
        #12;
        check("rst_dst_rdy", 32'(dst_rdy), 32'(0));
        check("rst_o_data",  32'(o_data),  32'(0));
        check("rst_o_lane",  32'(o_lane),  32'(0));
        check("rst_o_last",  32'(o_last),  32'(0));
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        // Full word, then sparse word, then single-lane words back to back,
        // then an empty word followed immediately by a lane-1 word.
        ack_pct = 100;
        drive(32'h4433_2211, 4'b1111);
        drain();
        drive(32'hDDCC_BBAA, 4'b1010);
        drain();
        drive(32'h1234_5678, 4'b0001);
        drive(32'h9ABC_DEF0, 4'b0100);
        drain();
        drive(32'h0BAD_F00D, 4'b0000);
        drive(32'h5566_7788, 4'b0010);
        drain();

        // Backpressure mid-word with a second word waiting.
        ack_pct = 0;
        drive(32'hA4A3_A2A1, 4'b1111);
        fork
            drive(32'hB4B3_B2B1, 4'b0110);
        join_none
        @(negedge i_clk);
        ack_pct = 100;
        @(negedge i_clk);
        ack_pct = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        hold_data = o_data;
        hold_lane = o_lane;
        check("stall_o_data_first", 32'(hold_data), 32'(8'hA2));
        for (int c = 0; c < 5; c++) begin
            check("stall_o_data", 32'(o_data), 32'(hold_data));
            check("stall_o_lane", 32'(o_lane), 32'(hold_lane));
            check("stall_src_ack", 32'(src_ack), 32'(0));
            @(negedge i_clk);
        end
        ack_pct = 100;
        wait fork;
        drain();

        // Reset after the first of three items.
        drive(32'hC4C3_C2C1, 4'b1011);
        @(posedge i_clk);
        #2;
        i_rst   = 1'b0;
        dst_ack = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_dst_rdy", 32'(dst_rdy), 32'(0));
        check("midrst_o_data",  32'(o_data),  32'(0));
        check("midrst_o_last",  32'(o_last),  32'(0));
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        drive(32'hE4E3_E2E1, 4'b1100);
        @(negedge i_clk);
        check("post_rst_first_lane", 32'(o_lane), 32'(2));
        check("post_rst_first_data", 32'(o_data), 32'(8'hE3));
        @(posedge i_clk);
        #1;
        drain();

        // Randomized traffic: random words, masks, gaps and consumer stalls.
        for (int w = 0; w < 300; w++) begin
            ack_pct = $urandom_range(30, 100);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge i_clk);
                #1;
            end
            drive($urandom, NLANE'($urandom));
        end
        ack_pct = 100;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sfifo_unpacker
